// File: rtl/mod_segment_transition_pkg.sv
// Shared types and constants for the modulation segment transition logic.
package mod_segment_transition_pkg;

    typedef enum logic [7:0] {
        SYNC_IDX = 8'h00,
        SYS_TIME = 8'h01,
        GPIO     = 8'h02,
        EXT      = 8'hF0
    } transition_mode_t;

    localparam logic [31:0] ModRepInfinite = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOOP = 2'd1,
        WAIT_TIME = 2'd2,
        WAIT_GPIO = 2'd3
    } mod_transition_state_t;

    function automatic logic is_valid_mode(input logic [7:0] mode);
        return (mode == SYNC_IDX) || (mode == SYS_TIME) ||
               (mode == GPIO) || (mode == EXT);
    endfunction

    // EXT waits on the loop end exactly like SYNC_IDX.
    function automatic mod_transition_state_t mode_to_state(input logic [7:0] mode);
        mod_transition_state_t st;
        case (mode)
            SYS_TIME: st = WAIT_TIME;
            GPIO:     st = WAIT_GPIO;
            default:  st = WAIT_LOOP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mod_segment_transition_rep_counter.sv
// Counts completed loops of the active segment; flags when REP+1 loops are done.
module segment_rep_counter
    import mod_segment_transition_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        loop_end,
    input  logic        swap,
    input  logic [31:0] rep,
    output logic        done
);

    logic [31:0] loop_cnt_q;
    logic [31:0] loop_cnt_d;
    logic        active;

    // Counting is meaningful only for a finite repetition value.
    assign active = en && (rep != ModRepInfinite);
    assign done   = active && loop_end && (loop_cnt_q == rep);

    // Restart on every swap; saturate at rep so the count never wraps.
    always_comb begin
        loop_cnt_d = loop_cnt_q;
        if (swap) begin
            loop_cnt_d = '0;
        end else if (active && loop_end && (loop_cnt_q != rep)) begin
            loop_cnt_d = loop_cnt_q + 32'd1;
        end
    end

    // Loop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            loop_cnt_q <= '0;
        end else begin
            loop_cnt_q <= loop_cnt_d;
        end
    end

endmodule

// File: rtl/mod_segment_transition.sv
// Decides when the modulation sampler switches segment, and stops or
// alternates it once a finite repetition count is reached.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | running the active segment, nothing pending
// WAIT_LOOP | request latched, waiting for the sampler loop end
// WAIT_TIME | request latched, waiting for system time >= value
// WAIT_GPIO | request latched, waiting for a rising GPIO edge
module mod_segment_transition
    import mod_segment_transition_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        UPDATE,
    input  logic        REQ_SEGMENT,
    input  logic [7:0]  TRANSITION_MODE,
    input  logic [63:0] TRANSITION_VALUE,
    input  logic [31:0] REP0,
    input  logic [31:0] REP1,
    input  logic        LOOP_END,
    input  logic [63:0] SYS_TIME,
    input  logic [3:0]  GPIO_IN,
    output logic        SEGMENT,
    output logic        SWAP,
    output logic        STOP,
    output logic        PENDING
);

    mod_transition_state_t state_q, state_d;
    logic        segment_q, segment_d;
    logic        swap_q, swap_d;
    logic        stop_q, stop_d;
    logic        ext_en_q, ext_en_d;
    logic        req_seg_q, req_seg_d;
    logic [63:0] value_q, value_d;
    logic [3:0]  gpio_prev_q, gpio_prev_d;

    logic        update_ok;
    logic        trigger;
    logic        rep_done;
    logic [1:0]  gpio_sel;
    logic [31:0] rep_active;

    assign update_ok  = UPDATE && is_valid_mode(TRANSITION_MODE);
    assign gpio_sel   = value_q[1:0];
    assign rep_active = segment_q ? REP1 : REP0;

    // A loop end in the swap cycle belongs to the old index and is not counted.
    segment_rep_counter u_rep_counter (
        .clk      (CLK),
        .rst      (RST),
        .en       ((state_q == IDLE) && !stop_q && !swap_q),
        .loop_end (LOOP_END),
        .swap     (swap_d),
        .rep      (rep_active),
        .done     (rep_done)
    );

    // Trigger of the pending request, evaluated against the latched request.
    always_comb begin
        trigger = 1'b0;
        case (state_q)
            WAIT_LOOP: trigger = LOOP_END;
            WAIT_TIME: trigger = (SYS_TIME >= value_q);
            WAIT_GPIO: trigger = GPIO_IN[gpio_sel] && !gpio_prev_q[gpio_sel];
            default:   trigger = 1'b0;
        endcase
    end

    // Next state: a new valid request always wins over a trigger or segment end.
    always_comb begin
        state_d     = state_q;
        segment_d   = segment_q;
        swap_d      = 1'b0;
        stop_d      = stop_q;
        ext_en_d    = ext_en_q;
        req_seg_d   = req_seg_q;
        value_d     = value_q;
        gpio_prev_d = GPIO_IN;
        if (update_ok) begin
            req_seg_d = REQ_SEGMENT;
            value_d   = TRANSITION_VALUE;
            stop_d    = 1'b0;
            ext_en_d  = (TRANSITION_MODE == EXT);
            state_d   = mode_to_state(TRANSITION_MODE);
        end else if (trigger) begin
            segment_d = req_seg_q;
            swap_d    = 1'b1;
            state_d   = IDLE;
        end else if (rep_done) begin
            if (ext_en_q) begin
                segment_d = !segment_q;
                swap_d    = 1'b1;
            end else begin
                stop_d = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            segment_q   <= 1'b0;
            swap_q      <= 1'b0;
            stop_q      <= 1'b0;
            ext_en_q    <= 1'b0;
            req_seg_q   <= 1'b0;
            value_q     <= '0;
            gpio_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            segment_q   <= segment_d;
            swap_q      <= swap_d;
            stop_q      <= stop_d;
            ext_en_q    <= ext_en_d;
            req_seg_q   <= req_seg_d;
            value_q     <= value_d;
            gpio_prev_q <= gpio_prev_d;
        end
    end

    assign SEGMENT = segment_q;
    assign SWAP    = swap_q;
    assign STOP    = stop_q;
    assign PENDING = (state_q != IDLE);

endmodule

// File: tb/tb_mod_segment_transition.sv
// Directed bench for mod_segment_transition.
module tb_mod_segment_transition;

    logic        CLK = 1'b0;
    logic        RST;
    logic        UPDATE;
    logic        REQ_SEGMENT;
    logic [7:0]  TRANSITION_MODE;
    logic [63:0] TRANSITION_VALUE;
    logic [31:0] REP0;
    logic [31:0] REP1;
    logic        LOOP_END;
    logic [63:0] SYS_TIME;
    logic [3:0]  GPIO_IN;
    logic        SEGMENT;
    logic        SWAP;
    logic        STOP;
    logic        PENDING;

    int total = 0;
    int bad   = 0;

    logic [5:0] ext_swap_exp = 6'b110110;
    logic [5:0] ext_seg_exp  = 6'b010010;

    mod_segment_transition dut (
        .CLK              (CLK),
        .RST              (RST),
        .UPDATE           (UPDATE),
        .REQ_SEGMENT      (REQ_SEGMENT),
        .TRANSITION_MODE  (TRANSITION_MODE),
        .TRANSITION_VALUE (TRANSITION_VALUE),
        .REP0             (REP0),
        .REP1             (REP1),
        .LOOP_END         (LOOP_END),
        .SYS_TIME         (SYS_TIME),
        .GPIO_IN          (GPIO_IN),
        .SEGMENT          (SEGMENT),
        .SWAP             (SWAP),
        .STOP             (STOP),
        .PENDING          (PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then stable for the new cycle.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic request(input logic seg, input logic [7:0] mode, input logic [63:0] val);
        UPDATE           = 1'b1;
        REQ_SEGMENT      = seg;
        TRANSITION_MODE  = mode;
        TRANSITION_VALUE = val;
        step();
        UPDATE = 1'b0;
    endtask

    initial begin
        RST = 1'b1; UPDATE = 1'b0; REQ_SEGMENT = 1'b0; TRANSITION_MODE = 8'h00;
        TRANSITION_VALUE = '0; REP0 = 32'hFFFF_FFFF; REP1 = 32'hFFFF_FFFF;
        LOOP_END = 1'b0; SYS_TIME = '0; GPIO_IN = 4'h0;
        step(); step();
        RST = 1'b0;
        chk("rst_segment", SEGMENT, 0);
        chk("rst_swap", SWAP, 0);
        chk("rst_stop", STOP, 0);
        chk("rst_pending", PENDING, 0);

        // SYNC_IDX to segment 1, loop end after a few cycles
        request(1'b1, 8'h00, 64'd0);
        chk("sync_pending", PENDING, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sync_wait_swap", SWAP, 0);
            chk("sync_wait_pending", PENDING, 1);
        end
        LOOP_END = 1'b1; step(); LOOP_END = 1'b0;
        chk("sync_segment", SEGMENT, 1);
        chk("sync_swap", SWAP, 1);
        chk("sync_pending_clr", PENDING, 0);
        step();
        chk("sync_swap_once", SWAP, 0);

        // SYS_TIME to segment 0 at time 1000
        SYS_TIME = 64'd990;
        request(1'b0, 8'h01, 64'd1000);
        for (int t = 990; t <= 1003; t++) begin
            SYS_TIME = 64'(t);
            step();
            chk("time_swap", SWAP, (t == 1000) ? 64'd1 : 64'd0);
        end
        chk("time_segment", SEGMENT, 0);

        // time already in the past fires straight away
        SYS_TIME = 64'd2000;
        request(1'b1, 8'h01, 64'd5);
        chk("past_latch_swap", SWAP, 0);
        chk("past_latch_pending", PENDING, 1);
        step();
        chk("past_swap", SWAP, 1);
        chk("past_segment", SEGMENT, 1);

        // GPIO line 2; line 1 activity and a level held from latch are ignored
        GPIO_IN = 4'b0100;
        request(1'b0, 8'h02, 64'd2);
        GPIO_IN = 4'b0110; step(); chk("gpio_other_line", SWAP, 0);
        GPIO_IN = 4'b0100; step(); chk("gpio_other_fall", SWAP, 0);
        step(); chk("gpio_held_high", SWAP, 0);
        chk("gpio_pending", PENDING, 1);
        GPIO_IN = 4'b0000; step(); chk("gpio_fall", SWAP, 0);
        GPIO_IN = 4'b0100; step();
        chk("gpio_rise_swap", SWAP, 1);
        chk("gpio_rise_segment", SEGMENT, 0);
        GPIO_IN = 4'b0000;

        // finite repetition: REP0=2 stops after the third counted loop
        REP0 = 32'd2;
        request(1'b0, 8'h00, 64'd0);
        LOOP_END = 1'b1; step();
        chk("rep_swap", SWAP, 1);
        step(); LOOP_END = 1'b0;      // loop end during the swap cycle is not counted
        chk("rep_swap_cycle_loop", STOP, 0);
        step();
        for (int k = 1; k <= 3; k++) begin
            LOOP_END = 1'b1; step(); LOOP_END = 1'b0;
            chk("rep_stop", STOP, (k == 3) ? 64'd1 : 64'd0);
            step();
            chk("rep_stop_hold", STOP, (k == 3) ? 64'd1 : 64'd0);
        end
        LOOP_END = 1'b1; step(); LOOP_END = 1'b0;
        chk("rep_stop_sticky", STOP, 1);
        chk("rep_no_swap", SWAP, 0);
        request(1'b1, 8'h55, 64'd0);
        chk("bad_mode_stop", STOP, 1);
        chk("bad_mode_pending", PENDING, 0);
        request(1'b1, 8'h00, 64'd0);
        chk("update_clears_stop", STOP, 0);
        chk("update_pending", PENDING, 1);

        // replace pending SYNC_IDX->1 with SYS_TIME->0 on a loop-end cycle
        SYS_TIME = 64'd2000;
        LOOP_END = 1'b1;
        request(1'b0, 8'h01, 64'd3000);
        LOOP_END = 1'b0;
        chk("replace_swap", SWAP, 0);
        chk("replace_segment", SEGMENT, 0);
        chk("replace_pending", PENDING, 1);
        step();
        chk("replace_wait", SWAP, 0);
        SYS_TIME = 64'd3000; step();
        chk("replace_time_swap", SWAP, 1);
        chk("replace_time_seg", SEGMENT, 0);

        // reset while waiting discards the request
        request(1'b1, 8'h01, 64'd4000);
        chk("rst_wait_pending", PENDING, 1);
        RST = 1'b1; step(); RST = 1'b0;
        chk("rst_wait_clr", PENDING, 0);
        SYS_TIME = 64'd5000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_wait_no_swap", SWAP, 0);
            chk("rst_wait_segment", SEGMENT, 0);
        end

        // EXT alternation: seg0 x2 loops, seg1 x1 loop, repeating
        REP0 = 32'd1; REP1 = 32'd0;
        request(1'b0, 8'hF0, 64'd0);
        LOOP_END = 1'b1; step(); LOOP_END = 1'b0;
        chk("ext_first_swap", SWAP, 1);
        chk("ext_first_seg", SEGMENT, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            LOOP_END = 1'b1; step(); LOOP_END = 1'b0;
            chk("ext_swap", SWAP, 64'(ext_swap_exp[i]));
            chk("ext_seg", SEGMENT, 64'(ext_seg_exp[i]));
            chk("ext_stop", STOP, 0);
            step(); step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
